display_scan_controller: RTL
============================

# display_scan_controller

Time-multiplexed scan controller for the 8-digit seven-segment display. It steps a 3-bit digit index through all eight digits, PWM-dims each digit slot and double-buffers the displayed value so that updates land only on frame boundaries. `digit_sel` drives the 3-to-8 digit decoder; `nibble`/`dp` feed the segment encoder.

## Interface
- `PHASE_LEN`, default 6250: clock cycles per brightness phase, ≥1. One slot is 8 phases; one frame is 8 slots (64·PHASE_LEN cycles; 125 Hz at 50 MHz).
- `clk` in 1: system clock, all logic on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `en` in 1: scan enable; low = display dark and counters held.
- `load` in 1: one-cycle strobe that captures `data_in`/`dp_in`/`digit_en` into the shadow buffer.
- `data_in` in 32: eight BCD/hex nibbles; digit k = bits [4k+3:4k].
- `dp_in` in 8: decimal point per digit.
- `digit_en` in 8: per-digit enable; a disabled digit is blanked for its slot but still consumes its slot time.
- `brightness` in 3: lit phases per slot (0 = off, 7 = 7/8 duty); sampled live.
- `digit_sel` out 3: current digit index, to the 3-to-8 decoder.
- `nibble` out 4: active-buffer nibble for `digit_sel`.
- `dp` out 1: active-buffer decimal point for `digit_sel`.
- `blank` out 1: 1 = segments/decoder must be off this cycle.
- `pending` out 1: shadow buffer holds data not yet committed.
- `frame_done` out 1: one-cycle pulse on each commit/frame wrap.

## Operation
- Counters: `pcnt` 0..PHASE_LEN-1, `phase` 0..7, `slot` 0..7 (= `digit_sel`). `pcnt` increments every enabled cycle. On `pcnt`=PHASE_LEN-1, `pcnt` wraps to 0 and `phase` increments. On phase 7 wrap, `slot` increments modulo 8.
- Frame boundary: the cycle with `slot`=7, `phase`=7, `pcnt`=PHASE_LEN-1 and `en`=1. On that edge: active ← shadow if `pending`, `pending` ← 0, and `frame_done` is 1 for the following cycle. `frame_done` pulses on every boundary, even with nothing pending.
- Load: on `load`=1, shadow ← {`data_in`, `dp_in`, `digit_en`} and `pending` ← 1. This is accepted in any state, including `en`=0. Back-to-back loads: the last one wins.
- `load` on the boundary cycle: active takes the old shadow, shadow takes the new data, and `pending` stays 1.
- Blanking: `blank` = !en | (phase==0) | (phase > brightness) | !active_digit_en[slot]. Phase 0 is always dark as the anti-ghosting guard band.
- `nibble`/`dp` always reflect the active buffer at `slot`, including while blanked.
- Two states:
  - SCAN (`en`=1): counters advance.
  - HOLD (`en`=0): `pcnt`/`phase`/`slot` are forced to 0 on the next edge and `blank`=1. `pending` and the shadow buffer are retained.
  - HOLD→SCAN restarts at digit 0, phase 0.

## Timing
- Reset values: `digit_sel`=0, `nibble`=0, `dp`=0, `blank`=1, `pending`=0, `frame_done`=0; active and shadow buffers all zero, including `digit_en`.
- All outputs are registered and change on the same edge as the counters, with no extra pipeline stage.
- Load latency:
  - `pending` rises one cycle after `load`.
  - Visible data changes at the first frame boundary after that. The worst case is one full frame (64·PHASE_LEN cycles).
- `brightness` changes take effect on the next cycle's blank evaluation, with no resynchronisation.
- `rst` asserted mid-frame forces all reset values immediately (asynchronously). Scanning resumes from digit 0 on the first edge after release if `en`=1.
- PHASE_LEN=1: `phase` advances every cycle; all rules above still hold.

## Test plan
All scenarios use PHASE_LEN=2, so one slot = 16 cycles and one frame = 128 cycles.
- Reset, `en`=1, no load:
  - `digit_sel` steps 0→7 every 16 cycles and wraps.
  - `blank` stays 1 throughout, because the active `digit_en`=0.
  - `frame_done` pulses every 128 cycles.
- `load` with `data_in`=0x76543210, `dp_in`=0x01, `digit_en`=0xFF, `brightness`=7 mid-frame:
  - `pending`=1 the next cycle.
  - Old data is shown until the boundary.
  - After `frame_done`: `nibble`==`digit_sel` and `dp`=1 only on digit 0.
  - `blank`=0 exactly for phases 1-7 (14 of 16 cycles per slot); `pending`=0.
- Brightness sweep 0/3/7 → lit cycles per slot = 0/6/14.
- `digit_en`=0xA5 → `blank` stays 1 for the full slots of digits 1, 3, 4 and 6; slot timing is unchanged.
- `load` coincident with the boundary cycle:
  - Active takes the prior shadow and `pending` stays 1.
  - The new data appears one frame later.
- Mid-frame events:
  - `en` dropped at digit 5: `blank`=1 and `digit_sel`=0 the next cycle; `pending` is retained.
  - `en` raised again: the scan restarts at digit 0, phase 0.
  - `rst` pulsed mid-frame: all outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/display_scan_controller.sv
// display_scan_controller
// Scans an 8-digit seven-segment display one digit slot at a time. Each slot
// is split into 8 brightness phases of PHASE_LEN clocks. Displayed data is
// double-buffered, so new values only become visible on a frame boundary.
module display_scan_controller #(
    parameter int PHASE_LEN = 6250
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic        load_i,
    input  logic [31:0] data_in_i,
    input  logic [7:0]  dp_in_i,
    input  logic [7:0]  digit_en_i,
    input  logic [2:0]  brightness_i,
    output logic [2:0]  digit_sel_o,
    output logic [3:0]  nibble_o,
    output logic        dp_o,
    output logic        blank_o,
    output logic        pending_o,
    output logic        frame_done_o
);

    localparam int PCNT_W = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PHASE_LEN - 1);

    typedef enum logic {
        SCAN,
        HOLD
    } scan_state_t;

    scan_state_t       mode;
    logic              boundary;

    logic [PCNT_W-1:0] pcnt_q, pcnt_d;
    logic [2:0]        phase_q, phase_d;
    logic [2:0]        slot_q, slot_d;

    logic [31:0]       activeData_q, activeData_d;
    logic [7:0]        activeDp_q, activeDp_d;
    logic [7:0]        activeEn_q, activeEn_d;
    logic [31:0]       shadowData_q, shadowData_d;
    logic [7:0]        shadowDp_q, shadowDp_d;
    logic [7:0]        shadowEn_q, shadowEn_d;

    logic              pending_q, pending_d;
    logic              frameDone_q, frameDone_d;
    logic              blank_q, blank_d;
    logic              dp_q, dp_d;
    logic [3:0]        nibble_q, nibble_d;

    // Next-state logic. The outputs are computed from the next counter and
    // buffer values, so they change on the same edge as the counters.
    always_comb begin
        mode     = en_i ? SCAN : HOLD;
        boundary = 1'b0;
        pcnt_d   = '0;
        phase_d  = '0;
        slot_d   = '0;

        case (mode)
            SCAN: begin
                boundary = (pcnt_q == PCNT_LAST) && (phase_q == 3'd7) && (slot_q == 3'd7);
                if (pcnt_q == PCNT_LAST) begin
                    pcnt_d  = '0;
                    phase_d = phase_q + 3'd1;
                    slot_d  = (phase_q == 3'd7) ? slot_q + 3'd1 : slot_q;
                end else begin
                    pcnt_d  = pcnt_q + PCNT_W'(1);
                    phase_d = phase_q;
                    slot_d  = slot_q;
                end
            end
            default: begin
                pcnt_d  = '0;
                phase_d = '0;
                slot_d  = '0;
            end
        endcase

        // A load on the boundary cycle still commits the older shadow contents.
        activeData_d = activeData_q;
        activeDp_d   = activeDp_q;
        activeEn_d   = activeEn_q;
        if (boundary && pending_q) begin
            activeData_d = shadowData_q;
            activeDp_d   = shadowDp_q;
            activeEn_d   = shadowEn_q;
        end

        shadowData_d = shadowData_q;
        shadowDp_d   = shadowDp_q;
        shadowEn_d   = shadowEn_q;
        if (load_i) begin
            shadowData_d = data_in_i;
            shadowDp_d   = dp_in_i;
            shadowEn_d   = digit_en_i;
        end

        pending_d   = load_i | (pending_q & ~boundary);
        frameDone_d = boundary;

        // Phase 0 is always dark so the previous digit cannot ghost into this one.
        nibble_d = activeData_d[{slot_d, 2'b00} +: 4];
        dp_d     = activeDp_d[slot_d];
        blank_d  = (mode == HOLD) || (phase_d == 3'd0) || (phase_d > brightness_i)
                   || !activeEn_d[slot_d];
    end

    // State and output registers; reset darkens the display and clears both buffers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pcnt_q       <= '0;
            phase_q      <= '0;
            slot_q       <= '0;
            activeData_q <= '0;
            activeDp_q   <= '0;
            activeEn_q   <= '0;
            shadowData_q <= '0;
            shadowDp_q   <= '0;
            shadowEn_q   <= '0;
            pending_q    <= 1'b0;
            frameDone_q  <= 1'b0;
            blank_q      <= 1'b1;
            dp_q         <= 1'b0;
            nibble_q     <= '0;
        end else begin
            pcnt_q       <= pcnt_d;
            phase_q      <= phase_d;
            slot_q       <= slot_d;
            activeData_q <= activeData_d;
            activeDp_q   <= activeDp_d;
            activeEn_q   <= activeEn_d;
            shadowData_q <= shadowData_d;
            shadowDp_q   <= shadowDp_d;
            shadowEn_q   <= shadowEn_d;
            pending_q    <= pending_d;
            frameDone_q  <= frameDone_d;
            blank_q      <= blank_d;
            dp_q         <= dp_d;
            nibble_q     <= nibble_d;
        end
    end

    assign digit_sel_o  = slot_q;
    assign nibble_o     = nibble_q;
    assign dp_o         = dp_q;
    assign blank_o      = blank_q;
    assign pending_o    = pending_q;
    assign frame_done_o = frameDone_q;

endmodule
